// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and defaults for the data-memory arbiter:
//                FSM state encoding, transaction owner encoding and the
//                default address/data widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int AW_DEFAULT = 64;
    localparam int DW_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant between the fetch unit and the
//                load-store unit. Grants are combinational from the request
//                valids and the last granted owner; last_grant is updated on
//                an accepted request.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                en              - arbitration window (FSM idle)
//                req_ifu/req_lsu - request valids
//                update          - a grant was accepted this cycle
//                grant_ifu/lsu   - one-hot grant (0 when en is low)
//                winner          - owner that would win this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   req_ifu,
    input  logic   req_lsu,
    input  logic   update,
    output logic   grant_ifu,
    output logic   grant_lsu,
    output owner_t winner
);

    owner_t r_last_grant;
    logic   w_pick_lsu;

    // LSU wins when it is the only requester, or when both request and the
    // IFU had the previous grant.
    assign w_pick_lsu = req_lsu & (~req_ifu | (r_last_grant == OWN_IFU));

    assign winner    = w_pick_lsu ? OWN_LSU : OWN_IFU;
    assign grant_lsu = en & w_pick_lsu;
    assign grant_ifu = en & req_ifu & ~w_pick_lsu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= OWN_IFU;
        end else if (update) begin
            r_last_grant <= winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one data-memory port between the instruction-fetch
//                unit (read-only) and the load-store unit (read/write).
//                Round-robin arbitration, one transaction in flight, with a
//                programmable number of wait cycles before the access.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                ifu_req_*/ifu_addr  - fetch request channel
//                ifu_resp_*/ifu_rdata- fetch response channel
//                lsu_req_*/lsu_*     - load/store request channel
//                lsu_resp_*/lsu_rdata- load data / store ack channel
//                mem_*               - memory port (rdata same cycle as ce)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_we,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [DW-1:0] lsu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic [DW-1:0] mem_rdata
);

    // Wait-counter load value; unused when LATENCY is 0 (WAIT is skipped).
    localparam logic [3:0] c_wait_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t        r_state;
    state_t        w_state_nxt;
    owner_t        r_owner;
    owner_t        w_win;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [7:0]    r_wmask;
    logic [DW-1:0] r_rdata;
    logic          w_grant_en;
    logic          w_grant_ifu;
    logic          w_grant_lsu;
    logic          w_hs;
    logic          w_resp_done;

    // Ready is suppressed while rst_n is low: a handshake in that cycle
    // would be discarded by the reset.
    assign w_grant_en = rst_n & (r_state == IDLE);

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_grant_en),
        .req_ifu   (ifu_req_valid),
        .req_lsu   (lsu_req_valid),
        .update    (w_hs),
        .grant_ifu (w_grant_ifu),
        .grant_lsu (w_grant_lsu),
        .winner    (w_win)
    );

    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;
    // A grant is only raised for a valid requester, so any grant is a handshake.
    assign w_hs          = w_grant_ifu | w_grant_lsu;

    assign ifu_resp_valid = (r_state == RESP) & (r_owner == OWN_IFU);
    assign lsu_resp_valid = (r_state == RESP) & (r_owner == OWN_LSU);
    assign w_resp_done    = (ifu_resp_valid & ifu_resp_ready) |
                            (lsu_resp_valid & lsu_resp_ready);

    assign ifu_rdata = ifu_resp_valid ? r_rdata : '0;
    assign lsu_rdata = lsu_resp_valid ? r_rdata : '0;

    // Memory port is quiet outside the single ACCESS cycle.
    assign mem_ce    = (r_state == ACCESS);
    assign mem_we    = mem_ce & r_we;
    assign mem_addr  = mem_ce ? r_addr  : '0;
    assign mem_wdata = mem_ce ? r_wdata : '0;
    assign mem_wmask = mem_ce ? r_wmask : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = (LATENCY > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    if (w_resp_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_IFU;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wmask <= 8'd0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_owner <= w_win;
                r_cnt   <= c_wait_init;
                if (w_win == OWN_LSU) begin
                    r_addr  <= lsu_addr;
                    r_we    <= lsu_we;
                    r_wdata <= lsu_wdata;
                    r_wmask <= lsu_wmask;
                end else begin
                    // Fetches are always plain reads.
                    r_addr  <= ifu_addr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= 8'd0;
                end
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ACCESS) begin
                r_rdata <= r_we ? '0 : mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. Two instances
//                share the stimulus: dut1 with LATENCY=1, dut0 with LATENCY=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ifu_req_valid, ifu_resp_ready;
    logic        lsu_req_valid, lsu_we, lsu_resp_ready;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [7:0]  lsu_wmask;

    logic        ifu_req_ready_1, ifu_resp_valid_1, lsu_req_ready_1, lsu_resp_valid_1;
    logic        mem_ce_1, mem_we_1;
    logic [63:0] ifu_rdata_1, lsu_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic [7:0]  mem_wmask_1;

    logic        ifu_req_ready_0, ifu_resp_valid_0, lsu_req_ready_0, lsu_resp_valid_0;
    logic        mem_ce_0, mem_we_0;
    logic [63:0] ifu_rdata_0, lsu_rdata_0, mem_addr_0, mem_wdata_0, mem_rdata_0;
    logic [7:0]  mem_wmask_0;

    int n_cmp = 0;
    int n_err = 0;
    logic grants [4];
    int   n_g;

    // Memory contents: one known fetch word, everything else is ~address.
    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return (a == 64'h0000_0000_8000_0000) ? 64'h00000413_00100073 : ~a;
    endfunction

    assign mem_rdata_1 = mem_model(mem_addr_1);
    assign mem_rdata_0 = mem_model(mem_addr_0);

    mem_arbiter #(.LATENCY(1), .AW(64), .DW(64)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_1), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_1), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata_1),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_1), .lsu_addr(lsu_addr),
        .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_1), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata_1),
        .mem_addr(mem_addr_1), .mem_ce(mem_ce_1), .mem_we(mem_we_1),
        .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1), .mem_rdata(mem_rdata_1)
    );

    mem_arbiter #(.LATENCY(0), .AW(64), .DW(64)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_0), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_0), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata_0),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_0), .lsu_addr(lsu_addr),
        .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_0), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata_0),
        .mem_addr(mem_addr_0), .mem_ce(mem_ce_0), .mem_we(mem_we_0),
        .mem_wdata(mem_wdata_0), .mem_wmask(mem_wmask_0), .mem_rdata(mem_rdata_0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst_n low after two reset edges with all requester inputs idle.
    task automatic do_reset();
        rst_n          = 1'b0;
        ifu_req_valid  = 1'b0;
        ifu_resp_ready = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_we         = 1'b0;
        lsu_resp_ready = 1'b0;
        lsu_addr       = '0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        cyc();
        cyc();
    endtask

    // One LATENCY=0 read on dut0: handshake-to-resp_valid must be 2 cycles.
    task automatic txn0(input logic is_lsu, input logic [63:0] a, input string tag);
        int lat;
        bit got;
        if (is_lsu) begin
            lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = a;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = a;
        end
        #1;
        chk({tag, "_ready"}, is_lsu ? lsu_req_ready_0 : ifu_req_ready_0, 64'd1);
        cyc();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lat = -1;
        got = 1'b0;
        for (int k = 1; k <= 10 && !got; k++) begin
            if (is_lsu ? lsu_resp_valid_0 : ifu_resp_valid_0) begin
                got = 1'b1;
                lat = k;
            end else begin
                cyc();
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_data"}, is_lsu ? lsu_rdata_0 : ifu_rdata_0, mem_model(a));
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        ifu_req_valid = 1'b1;
        #1;
        chk("rst_ifu_ready", ifu_req_ready_1, 64'd0);
        ifu_req_valid = 1'b0;
        #1;
        chk("rst_lsu_ready", lsu_req_ready_1, 64'd0);
        chk("rst_ifu_rvalid", ifu_resp_valid_1, 64'd0);
        chk("rst_lsu_rvalid", lsu_resp_valid_1, 64'd0);
        chk("rst_ce", mem_ce_1, 64'd0);
        chk("rst_we", mem_we_1, 64'd0);
        chk("rst_addr", mem_addr_1, 64'd0);
        chk("rst_wdata", mem_wdata_1, 64'd0);
        chk("rst_ifu_rdata", ifu_rdata_1, 64'd0);
        rst_n = 1'b1;
        cyc();

        // ---------------- 1: lone IFU read, LATENCY=1 ----------------
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        #1;
        chk("t1_ifu_ready", ifu_req_ready_1, 64'd1);
        chk("t1_lsu_ready", lsu_req_ready_1, 64'd0);
        cyc();
        ifu_req_valid = 1'b0;
        ifu_addr      = 64'hDEAD_BEEF;
        #1;
        chk("t1_wait_ce", mem_ce_1, 64'd0);
        cyc();
        chk("t1_acc_ce", mem_ce_1, 64'd1);
        chk("t1_acc_we", mem_we_1, 64'd0);
        chk("t1_acc_addr", mem_addr_1, 64'h8000_0000);
        chk("t1_acc_wmask", 64'(mem_wmask_1), 64'd0);
        cyc();
        chk("t1_resp_ce", mem_ce_1, 64'd0);
        chk("t1_resp_valid", ifu_resp_valid_1, 64'd1);
        chk("t1_resp_data", ifu_rdata_1, 64'h00000413_00100073);
        chk("t1_lsu_rvalid", lsu_resp_valid_1, 64'd0);
        ifu_resp_ready = 1'b1;
        cyc();
        chk("t1_done", ifu_resp_valid_1, 64'd0);
        ifu_resp_ready = 1'b0;

        // ---------------- 2: LSU store ----------------
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wdata     = 64'h1122_3344_5566_7788;
        lsu_wmask     = 8'h0F;
        #1;
        chk("t2_ready", lsu_req_ready_1, 64'd1);
        cyc();
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = 8'hFF;
        #1;
        chk("t2_wait_ce", mem_ce_1, 64'd0);
        cyc();
        chk("t2_ce", mem_ce_1, 64'd1);
        chk("t2_we", mem_we_1, 64'd1);
        chk("t2_addr", mem_addr_1, 64'h8000_1000);
        chk("t2_wdata", mem_wdata_1, 64'h1122_3344_5566_7788);
        chk("t2_wmask", 64'(mem_wmask_1), 64'h0F);
        cyc();
        chk("t2_resp_ce", mem_ce_1, 64'd0);
        chk("t2_resp_valid", lsu_resp_valid_1, 64'd1);
        chk("t2_resp_data", lsu_rdata_1, 64'd0);
        chk("t2_ifu_rvalid", ifu_resp_valid_1, 64'd0);
        lsu_resp_ready = 1'b1;
        cyc();
        chk("t2_done", lsu_resp_valid_1, 64'd0);
        lsu_resp_ready = 1'b0;

        // ---------------- 3: round-robin order from reset ----------------
        do_reset();
        rst_n          = 1'b1;
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        lsu_we         = 1'b0;
        ifu_addr       = 64'h8000_0100;
        lsu_addr       = 64'h8000_2000;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) grants[i] = 1'bx;
        n_g = 0;
        #1;
        for (int k = 0; k < 40 && n_g < 4; k++) begin
            if (ifu_req_ready_1 | lsu_req_ready_1) begin
                chk("t3_onehot", 64'(ifu_req_ready_1 & lsu_req_ready_1), 64'd0);
                grants[n_g] = lsu_req_ready_1;
                n_g++;
            end
            if (lsu_resp_valid_1) chk("t3_lsu_data", lsu_rdata_1, mem_model(64'h8000_2000));
            if (ifu_resp_valid_1) chk("t3_ifu_data", ifu_rdata_1, mem_model(64'h8000_0100));
            cyc();
        end
        chk("t3_count", 64'(n_g), 64'd4);
        chk("t3_grant0_lsu", 64'(grants[0]), 64'd1);
        chk("t3_grant1_lsu", 64'(grants[1]), 64'd0);
        chk("t3_grant2_lsu", 64'(grants[2]), 64'd1);
        chk("t3_grant3_lsu", 64'(grants[3]), 64'd0);

        // ---------------- 4: LSU response stall ----------------
        do_reset();
        rst_n          = 1'b1;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 64'h8000_0200;
        lsu_req_valid  = 1'b1;
        lsu_we         = 1'b0;
        lsu_addr       = 64'h8000_3000;
        #1;
        chk("t4_lsu_ready", lsu_req_ready_1, 64'd1);
        chk("t4_ifu_ready0", ifu_req_ready_1, 64'd0);
        cyc();
        lsu_req_valid = 1'b0;
        lsu_addr      = 64'h0BAD;
        cyc();
        cyc();
        for (int k = 0; k < 10; k++) begin
            chk("t4_stall_valid", lsu_resp_valid_1, 64'd1);
            chk("t4_stall_data", lsu_rdata_1, mem_model(64'h8000_3000));
            chk("t4_stall_ifu_ready", ifu_req_ready_1, 64'd0);
            cyc();
        end
        lsu_resp_ready = 1'b1;
        cyc();
        chk("t4_release_valid", lsu_resp_valid_1, 64'd0);
        chk("t4_ifu_granted", ifu_req_ready_1, 64'd1);
        lsu_resp_ready = 1'b0;
        cyc();
        ifu_req_valid = 1'b0;
        cyc();
        cyc();
        chk("t4_ifu_resp", ifu_resp_valid_1, 64'd1);
        chk("t4_ifu_data", ifu_rdata_1, mem_model(64'h8000_0200));
        cyc();

        // ---------------- 5: reset during WAIT of a store ----------------
        do_reset();
        rst_n         = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 64'h8000_4000;
        lsu_wdata     = 64'hCAFE_F00D_0000_1111;
        lsu_wmask     = 8'hF0;
        #1;
        chk("t5_ready", lsu_req_ready_1, 64'd1);
        cyc();
        lsu_req_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("t5_wait_ce", mem_ce_1, 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t5_ce", mem_ce_1, 64'd0);
        chk("t5_we", mem_we_1, 64'd0);
        chk("t5_addr", mem_addr_1, 64'd0);
        chk("t5_wdata", mem_wdata_1, 64'd0);
        chk("t5_wmask", 64'(mem_wmask_1), 64'd0);
        chk("t5_lsu_rvalid", lsu_resp_valid_1, 64'd0);
        chk("t5_lsu_ready", lsu_req_ready_1, 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_no_access", mem_ce_1, 64'd0);
        end
        lsu_req_valid = 1'b1;
        #1;
        chk("t5_idle_ready", lsu_req_ready_1, 64'd1);
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;

        // ---------------- 6: LATENCY=0, alternating requesters ----------------
        do_reset();
        rst_n          = 1'b1;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        cyc();
        txn0(1'b0, 64'h8000_0000, "t6_ifu_a");
        txn0(1'b1, 64'h8000_5000, "t6_lsu_a");
        txn0(1'b0, 64'h8000_0008, "t6_ifu_b");
        txn0(1'b1, 64'h8000_5008, "t6_lsu_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
